axi_slave_mem_responder: RTL and testbench
==========================================

// Module: axi_slave_mem_responder
// PURPOSE
//  Synthesizable AXI4 slave with internal word-addressed memory; the responder for the team's dual-protocol master BFM AXI port.
//  Accepts AW/W/B and AR/R bursts (FIXED, INCR, WRAP), stores write data with byte strobes, returns read bursts.
//  Gives the AXI side of the testbench a self-checking memory target. Clock is axi_clk.
// PARAMETERS
//  AXI_DATA_WIDTH  64   data bus width; only 64 or 128 allowed (elaboration-time $fatal otherwise)
//  MEM_DEPTH       256  memory words of AXI_DATA_WIDTH bits; power of two
//  B_DELAY         0    extra cycles (0..15) from last W handshake to bvalid assertion
// PORTS
//  axi_clk      in   1      single clock; all logic on rising edge
//  rst          in   1      synchronous, active-high reset
//  axi_awaddr   in   32     write burst start byte address
//  axi_awlen    in   8      write beats minus 1
//  axi_awsize   in   3      write beat size; must equal log2(AXI_DATA_WIDTH/8)
//  axi_awburst  in   2      00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//  axi_awvalid  in   1      AW valid
//  axi_awready  out  1      AW ready
//  axi_wdata    in   AXI_DATA_WIDTH    write data
//  axi_wstrb    in   AXI_DATA_WIDTH/8  byte enables
//  axi_wlast    in   1      last write beat marker
//  axi_wvalid   in   1      W valid
//  axi_wready   out  1      W ready
//  axi_bresp    out  2      00 OKAY, 10 SLVERR
//  axi_bvalid   out  1      B valid
//  axi_bready   in   1      B ready
//  axi_araddr   in   32     read burst start byte address
//  axi_arlen    in   8      read beats minus 1
//  axi_arsize   in   3      read beat size; same rule as awsize
//  axi_arburst  in   2      same encoding as awburst
//  axi_arvalid  in   1      AR valid
//  axi_arready  out  1      AR ready
//  axi_rdata    out  AXI_DATA_WIDTH    read data
//  axi_rresp    out  2      00 OKAY, 10 SLVERR (per beat)
//  axi_rlast    out  1      last read beat marker
//  axi_rvalid   out  1      R valid
//  axi_rready   in   1      R ready
// BEHAVIOUR
//  Reset: all outputs 0 (awready, wready, bvalid, arready, rvalid, rlast, rdata, bresp, rresp); FSMs to IDLE; memory not cleared.
//   Reset mid-burst aborts the burst with no B/R completion; awready/arready return to 1 the cycle after rst deasserts.
//  Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE. W_IDLE: awready=1; AW handshake latches addr/len/burst/size, sets wready=1 next cycle.
//   W_DATA: each wvalid&wready beat writes bytes where wstrb=1 to mem[idx], then advances addr; beat counter counts to awlen.
//   Beat awlen ends W_DATA (wready=0 next cycle) whatever wlast says; wlast mismatch (early or missing) sets the error flag.
//   W_RESP: bvalid rises B_DELAY+1 cycles after last W handshake; bvalid/bresp held until bready; then W_IDLE.
//  Read FSM R_IDLE->R_DATA->R_IDLE. R_IDLE: arready=1; AR handshake -> first rvalid exactly 1 cycle later (registered rdata).
//   R_DATA: rdata/rresp/rlast held stable while rvalid&!rready; next beat presented the cycle after each handshake.
//   rlast=1 only on beat arlen; handshake on rlast -> R_IDLE, arready=1 next cycle.
//  Word index idx = addr[log2(AXI_DATA_WIDTH/8) +: log2(MEM_DEPTH)]; addr >= MEM_DEPTH*AXI_DATA_WIDTH/8 is out of range.
//  Address update: FIXED unchanged; INCR +AXI_DATA_WIDTH/8 (wraps at 2^32); WRAP wraps inside aligned (len+1)*bytes window.
//  SLVERR cases: out-of-range beat (write dropped, read returns 0); size != full width (beat still full width);
//   WRAP with len not in {1,3,7,15} (treated as INCR); burst 11 (treated as INCR); wlast mismatch. bresp is sticky over burst.
//  Read and write channels are fully independent; same-cycle write and read of one word: read returns pre-write data.
//  One outstanding transaction per direction; no IDs, no reordering.
// TESTING
//  1 64-bit: write 0x10 data 0xDEADBEEF_CAFEF00D len0 INCR, read 0x10 -> bresp 00; rdata matches, rresp 00, rlast 1 on single beat
//  2 INCR len3 from 0x0 all 0xFF.., then beat2 rewrite with wstrb 0x0F data 0 -> word2 reads 0xFFFFFFFF_00000000, others 0xFF..
//  3 WRAP len3 at 0x18 (64-bit) data 1,2,3,4 -> words 3,0,1,2 hold 1,2,3,4; INCR read 0x0 len3 returns 2,3,4,1
//  4 INCR read len3 with rready low 3 cycles on beat1 -> rdata/rvalid/rlast stable while stalled; rlast only on beat 3
//  5 write to 0x10000 (MEM_DEPTH 256) -> bresp 10, memory unchanged; read same addr -> rdata 0, rresp 10
//  6 rst pulsed 1 cycle during W_DATA of len7 burst -> bvalid never rises, outputs 0 next cycle, next write/read passes

Source files
------------

// File: rtl/axi_slave_mem_responder.sv
// AXI4 slave memory responder: a word-addressed internal memory serving
// independent write (AW/W/B) and read (AR/R) bursts of type FIXED, INCR
// and WRAP, with byte strobes and per-transaction SLVERR reporting.
//
// Ports
//   axi_clk, rst             clock, synchronous active-high reset
//   axi_aw*                  write address channel (addr, len, size, burst)
//   axi_w*                   write data channel (data, strobes, last)
//   axi_b*                   write response channel
//   axi_ar*                  read address channel (addr, len, size, burst)
//   axi_r*                   read data channel (data, resp, last)
module axi_slave_mem_responder #(
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned MEM_DEPTH      = 256,
  parameter int unsigned B_DELAY        = 0
) (
  input  logic                          axi_clk,
  input  logic                          rst,
  input  logic [31:0]                   axi_awaddr,
  input  logic [7:0]                    axi_awlen,
  input  logic [2:0]                    axi_awsize,
  input  logic [1:0]                    axi_awburst,
  input  logic                          axi_awvalid,
  output logic                          axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   axi_wstrb,
  input  logic                          axi_wlast,
  input  logic                          axi_wvalid,
  output logic                          axi_wready,
  output logic [1:0]                    axi_bresp,
  output logic                          axi_bvalid,
  input  logic                          axi_bready,
  input  logic [31:0]                   axi_araddr,
  input  logic [7:0]                    axi_arlen,
  input  logic [2:0]                    axi_arsize,
  input  logic [1:0]                    axi_arburst,
  input  logic                          axi_arvalid,
  output logic                          axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]     axi_rdata,
  output logic [1:0]                    axi_rresp,
  output logic                          axi_rlast,
  output logic                          axi_rvalid,
  input  logic                          axi_rready
);

  localparam int unsigned BYTES     = AXI_DATA_WIDTH / 8;
  localparam int unsigned OFF_W     = $clog2(BYTES);
  localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
  localparam int unsigned MEM_BYTES = MEM_DEPTH * BYTES;
  localparam int unsigned DLY_W     = 4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  generate
    if (!(AXI_DATA_WIDTH == 64 || AXI_DATA_WIDTH == 128)) begin : g_bad_width
      $fatal(1, "axi_slave_mem_responder: AXI_DATA_WIDTH must be 64 or 128");
    end
  endgenerate

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Only power-of-two WRAP lengths of 2/4/8/16 beats are legal.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Burst-level error: wrong beat size, reserved burst, or illegal WRAP length.
  function automatic logic cfg_err(input logic [2:0] size, input logic [1:0] burst,
                                   input logic [7:0] len);
    return (size != 3'(OFF_W)) || (burst == BURST_RSVD) ||
           ((burst == BURST_WRAP) && !wrap_len_ok(len));
  endfunction

  // Illegal WRAP and reserved bursts fall back to INCR addressing.
  function automatic logic [1:0] eff_burst(input logic [1:0] burst, input logic [7:0] len);
    logic [1:0] res;
    res = burst;
    if (burst == BURST_RSVD || (burst == BURST_WRAP && !wrap_len_ok(len))) res = BURST_INCR;
    return res;
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [1:0] burst);
    logic [31:0] inc, span, mask, res;
    inc  = addr + 32'(BYTES);
    span = (32'(len) + 32'd1) << OFF_W;
    mask = span - 32'd1;
    case (burst)
      BURST_FIXED: res = addr;
      BURST_WRAP:  res = (addr & ~mask) | (inc & mask);
      default:     res = inc;
    endcase
    return res;
  endfunction

  function automatic logic in_range(input logic [31:0] addr);
    return addr < 32'(MEM_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    return addr[OFF_W +: IDX_W];
  endfunction

  // ---------------------------------------------------------------- write side
  w_state_t         w_state, w_next;
  logic [31:0]      waddr;
  logic [7:0]       wlen, wcnt;
  logic [1:0]       wburst;
  logic             werr, werr_nxt;
  logic [DLY_W-1:0] dcnt, dcnt_nxt;
  logic             bvalid_nxt;
  logic [1:0]       bresp_nxt;
  logic             aw_hs, w_hs, w_last_beat, b_hs;

  assign aw_hs       = axi_awvalid && axi_awready;
  assign w_hs        = axi_wvalid && axi_wready;
  assign w_last_beat = w_hs && (wcnt == wlen);
  assign b_hs        = axi_bvalid && axi_bready;

  // Write FSM next state, error accumulation and response timing.
  always_comb begin
    w_next   = w_state;
    werr_nxt = werr;
    dcnt_nxt = dcnt;
    case (w_state)
      W_IDLE: if (aw_hs) w_next = W_DATA;
      W_DATA: if (w_last_beat) w_next = W_RESP;
      W_RESP: if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
    if (aw_hs) werr_nxt = cfg_err(axi_awsize, axi_awburst, axi_awlen);
    if (w_hs)  werr_nxt = werr || !in_range(waddr) || (axi_wlast != (wcnt == wlen));
    // Delay counter loads on the final beat and counts down while awaiting B.
    if (w_last_beat) dcnt_nxt = DLY_W'(B_DELAY);
    else if (w_state == W_RESP && dcnt != '0) dcnt_nxt = dcnt - DLY_W'(1);
    bvalid_nxt = (w_next == W_RESP) && (dcnt_nxt == '0);
    bresp_nxt  = bvalid_nxt ? (werr_nxt ? RESP_SLVERR : RESP_OKAY) : RESP_OKAY;
  end

  always_ff @(posedge axi_clk) begin
    if (rst) begin
      w_state     <= W_IDLE;
      axi_awready <= 1'b0;
      axi_wready  <= 1'b0;
      axi_bvalid  <= 1'b0;
      axi_bresp   <= RESP_OKAY;
      waddr       <= '0;
      wlen        <= '0;
      wburst      <= BURST_FIXED;
      wcnt        <= '0;
      werr        <= 1'b0;
      dcnt        <= '0;
    end else begin
      w_state     <= w_next;
      axi_awready <= (w_next == W_IDLE);
      axi_wready  <= (w_next == W_DATA);
      axi_bvalid  <= bvalid_nxt;
      axi_bresp   <= bresp_nxt;
      werr        <= werr_nxt;
      dcnt        <= dcnt_nxt;
      if (aw_hs) begin
        waddr  <= axi_awaddr;
        wlen   <= axi_awlen;
        wburst <= eff_burst(axi_awburst, axi_awlen);
        wcnt   <= '0;
      end else if (w_hs) begin
        waddr <= next_addr(waddr, wlen, wburst);
        wcnt  <= wcnt + 8'd1;
      end
    end
  end

  // Byte-strobed memory write; out-of-range beats are dropped.
  always_ff @(posedge axi_clk) begin
    if (w_hs && !rst && in_range(waddr)) begin
      for (int b = 0; b < int'(BYTES); b++) begin
        if (axi_wstrb[b]) mem[word_idx(waddr)][8*b +: 8] <= axi_wdata[8*b +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read side
  r_state_t    r_state, r_next;
  logic [31:0] raddr;
  logic [7:0]  rlen, rcnt;
  logic [1:0]  rburst;
  logic        rcfg;
  logic        ar_hs, r_hs, r_load;
  logic [31:0] rd_addr;
  logic [7:0]  rd_len, rd_cnt;
  logic [1:0]  rd_burst;
  logic        rd_err;

  assign ar_hs = axi_arvalid && axi_arready;
  assign r_hs  = axi_rvalid && axi_rready;

  // Read FSM next state and selection of the beat to present next.
  always_comb begin
    r_next   = r_state;
    rd_addr  = raddr;
    rd_len   = rlen;
    rd_burst = rburst;
    rd_cnt   = rcnt + 8'd1;
    rd_err   = rcfg;
    case (r_state)
      R_IDLE: if (ar_hs) r_next = R_DATA;
      R_DATA: if (r_hs && axi_rlast) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
    if (r_state == R_IDLE) begin
      rd_addr  = axi_araddr;
      rd_len   = axi_arlen;
      rd_burst = eff_burst(axi_arburst, axi_arlen);
      rd_cnt   = '0;
      rd_err   = cfg_err(axi_arsize, axi_arburst, axi_arlen);
    end
    r_load = ar_hs || (r_hs && !axi_rlast);
  end

  always_ff @(posedge axi_clk) begin
    if (rst) begin
      r_state     <= R_IDLE;
      axi_arready <= 1'b0;
      axi_rvalid  <= 1'b0;
      axi_rlast   <= 1'b0;
      axi_rdata   <= '0;
      axi_rresp   <= RESP_OKAY;
      raddr       <= '0;
      rlen        <= '0;
      rcnt        <= '0;
      rburst      <= BURST_FIXED;
      rcfg        <= 1'b0;
    end else begin
      r_state     <= r_next;
      axi_arready <= (r_next == R_IDLE);
      axi_rvalid  <= (r_next == R_DATA);
      if (ar_hs) begin
        rlen   <= axi_arlen;
        rburst <= rd_burst;
        rcfg   <= rd_err;
      end
      // Registered read: pre-write data is returned on a same-cycle collision.
      if (r_load) begin
        axi_rdata <= in_range(rd_addr) ? mem[word_idx(rd_addr)] : '0;
        axi_rresp <= (rd_err || !in_range(rd_addr)) ? RESP_SLVERR : RESP_OKAY;
        axi_rlast <= (rd_cnt == rd_len);
        raddr     <= next_addr(rd_addr, rd_len, rd_burst);
        rcnt      <= rd_cnt;
      end else if (r_hs && axi_rlast) begin
        axi_rlast <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_slave_mem_responder.sv
// Directed self-checking bench for axi_slave_mem_responder (64-bit, 256 words).
module tb_axi_slave_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst;
  logic        awvalid, awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic        arvalid, arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] wbuf [16];
  logic [63:0] ebuf [16];
  logic [1:0]  resp;
  logic        saw_b;

  always #5 clk = ~clk;

  axi_slave_mem_responder #(.AXI_DATA_WIDTH(64), .MEM_DEPTH(256), .B_DELAY(0)) dut (
    .axi_clk(clk), .rst(rst),
    .axi_awaddr(awaddr), .axi_awlen(awlen), .axi_awsize(awsize), .axi_awburst(awburst),
    .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast), .axi_wvalid(wvalid),
    .axi_wready(wready),
    .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
    .axi_araddr(araddr), .axi_arlen(arlen), .axi_arsize(arsize), .axi_arburst(arburst),
    .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_rdata(rdata), .axi_rresp(rresp), .axi_rlast(rlast), .axi_rvalid(rvalid),
    .axi_rready(rready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Full write burst; wlast is asserted on beat wlast_at. Data comes from wbuf.
  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size,
                           input logic [7:0] strb, input int wlast_at,
                           output logic [1:0] resp_o);
    awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
    for (int k = 0; k < 50 && !awready; k++) @(negedge clk);
    chk("aw_ready", 64'(awready), 64'd1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wbuf[i]; wstrb = strb; wlast = (i == wlast_at); wvalid = 1'b1;
      for (int k = 0; k < 50 && !wready; k++) @(negedge clk);
      chk("w_ready", 64'(wready), 64'd1);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("b_latency", 64'(bvalid), 64'd1);
    bready = 1'b1;
    for (int k = 0; k < 50 && !bvalid; k++) @(negedge clk);
    resp_o = bresp;
    @(negedge clk);
    bready = 1'b0;
    chk("b_done", 64'(bvalid), 64'd0);
  endtask

  // Read burst checked against ebuf; optional rready stall on one beat.
  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size,
                          input int stall_at, input int stall_n,
                          input logic [1:0] exp_resp);
    araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
    for (int k = 0; k < 50 && !arready; k++) @(negedge clk);
    chk("ar_ready", 64'(arready), 64'd1);
    @(negedge clk);
    arvalid = 1'b0;
    chk("r_latency", 64'(rvalid), 64'd1);
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_at) begin
        rready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          chk("stall_rvalid", 64'(rvalid), 64'd1);
          chk("stall_rdata", rdata, ebuf[i]);
          chk("stall_rlast", 64'(rlast), 64'(i == int'(len)));
        end
      end
      rready = 1'b1;
      for (int k = 0; k < 50 && !rvalid; k++) @(negedge clk);
      chk("rvalid", 64'(rvalid), 64'd1);
      chk("rdata", rdata, ebuf[i]);
      chk("rresp", 64'(rresp), 64'(exp_resp));
      chk("rlast", 64'(rlast), 64'(i == int'(len)));
      @(negedge clk);
    end
    rready = 1'b0;
    chk("r_done", 64'(rvalid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    awaddr = '0; awlen = '0; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arlen = '0; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_wready",  64'(wready),  64'd0);
    chk("rst_bvalid",  64'(bvalid),  64'd0);
    chk("rst_rvalid",  64'(rvalid),  64'd0);
    chk("rst_rdata",   rdata,        64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_awready", 64'(awready), 64'd1);
    chk("post_rst_arready", 64'(arready), 64'd1);

    // 1: single-beat write then read
    wbuf[0] = 64'hDEADBEEF_CAFEF00D;
    axi_write(32'h10, 8'd0, 2'b01, 3'd3, 8'hFF, 0, resp);
    chk("t1_bresp", 64'(resp), 64'd0);
    ebuf[0] = 64'hDEADBEEF_CAFEF00D;
    axi_read(32'h10, 8'd0, 2'b01, 3'd3, -1, 0, 2'b00);

    // 2: INCR fill then partial-strobe rewrite of word 2
    for (int i = 0; i < 4; i++) wbuf[i] = '1;
    axi_write(32'h0, 8'd3, 2'b01, 3'd3, 8'hFF, 3, resp);
    chk("t2_bresp_fill", 64'(resp), 64'd0);
    wbuf[0] = 64'd0;
    axi_write(32'h10, 8'd0, 2'b01, 3'd3, 8'h0F, 0, resp);
    chk("t2_bresp_strb", 64'(resp), 64'd0);
    ebuf[0] = '1; ebuf[1] = '1; ebuf[2] = 64'hFFFFFFFF_00000000; ebuf[3] = '1;
    axi_read(32'h0, 8'd3, 2'b01, 3'd3, -1, 0, 2'b00);

    // 3: WRAP len3 starting at word 3
    for (int i = 0; i < 4; i++) wbuf[i] = 64'(i + 1);
    axi_write(32'h18, 8'd3, 2'b10, 3'd3, 8'hFF, 3, resp);
    chk("t3_bresp", 64'(resp), 64'd0);
    ebuf[0] = 64'd2; ebuf[1] = 64'd3; ebuf[2] = 64'd4; ebuf[3] = 64'd1;
    axi_read(32'h0, 8'd3, 2'b01, 3'd3, -1, 0, 2'b00);

    // 4: same read with a 3-cycle rready stall on beat 1
    axi_read(32'h0, 8'd3, 2'b01, 3'd3, 1, 3, 2'b00);

    // 5: out-of-range write is dropped (would alias word 0), read returns 0/SLVERR
    wbuf[0] = 64'h5555_5555_5555_5555;
    axi_write(32'h10000, 8'd0, 2'b01, 3'd3, 8'hFF, 0, resp);
    chk("t5_bresp", 64'(resp), 64'd2);
    ebuf[0] = 64'd2;
    axi_read(32'h0, 8'd0, 2'b01, 3'd3, -1, 0, 2'b00);
    ebuf[0] = 64'd0;
    axi_read(32'h10000, 8'd0, 2'b01, 3'd3, -1, 0, 2'b10);

    // FIXED burst: both beats hit word 4, last one wins
    wbuf[0] = 64'd7; wbuf[1] = 64'd8;
    axi_write(32'h20, 8'd1, 2'b00, 3'd3, 8'hFF, 1, resp);
    chk("fixed_bresp", 64'(resp), 64'd0);
    ebuf[0] = 64'd8;
    axi_read(32'h20, 8'd0, 2'b01, 3'd3, -1, 0, 2'b00);

    // WRAP with illegal len2 behaves as INCR but reports SLVERR
    wbuf[0] = 64'hA; wbuf[1] = 64'hB; wbuf[2] = 64'hC;
    axi_write(32'h28, 8'd2, 2'b10, 3'd3, 8'hFF, 2, resp);
    chk("badwrap_bresp", 64'(resp), 64'd2);
    ebuf[0] = 64'hA; ebuf[1] = 64'hB; ebuf[2] = 64'hC;
    axi_read(32'h28, 8'd2, 2'b01, 3'd3, -1, 0, 2'b00);

    // Narrow size and early wlast both flag SLVERR
    wbuf[0] = 64'h1111;
    axi_write(32'h40, 8'd0, 2'b01, 3'd2, 8'hFF, 0, resp);
    chk("size_bresp", 64'(resp), 64'd2);
    wbuf[0] = 64'h21; wbuf[1] = 64'h22;
    axi_write(32'h50, 8'd1, 2'b01, 3'd3, 8'hFF, 0, resp);
    chk("wlast_bresp", 64'(resp), 64'd2);
    ebuf[0] = 64'h21; ebuf[1] = 64'h22;
    axi_read(32'h50, 8'd1, 2'b11, 3'd3, -1, 0, 2'b10);
    ebuf[0] = 64'd8;
    axi_read(32'h20, 8'd0, 2'b01, 3'd2, -1, 0, 2'b10);

    // 6: reset pulse in the middle of a len7 write burst
    awaddr = 32'h60; awlen = 8'd7; awburst = 2'b01; awsize = 3'd3; awvalid = 1'b1;
    for (int k = 0; k < 50 && !awready; k++) @(negedge clk);
    chk("t6_aw_ready", 64'(awready), 64'd1);
    @(negedge clk);
    awvalid = 1'b0;
    wdata = 64'h99; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
    chk("t6_wready", 64'(wready), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1; wvalid = 1'b0;
    @(negedge clk);
    chk("t6_rst_awready", 64'(awready), 64'd0);
    chk("t6_rst_wready",  64'(wready),  64'd0);
    chk("t6_rst_bvalid",  64'(bvalid),  64'd0);
    chk("t6_rst_arready", 64'(arready), 64'd0);
    chk("t6_rst_rdata",   rdata,        64'd0);
    chk("t6_rst_rresp",   64'(rresp),   64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_awready_back", 64'(awready), 64'd1);
    chk("t6_arready_back", 64'(arready), 64'd1);
    saw_b = 1'b0;
    for (int k = 0; k < 10; k++) begin
      saw_b = saw_b | bvalid;
      @(negedge clk);
    end
    chk("t6_no_bvalid", 64'(saw_b), 64'd0);
    wbuf[0] = 64'h1234;
    axi_write(32'h60, 8'd0, 2'b01, 3'd3, 8'hFF, 0, resp);
    chk("t6_bresp", 64'(resp), 64'd0);
    ebuf[0] = 64'h1234;
    axi_read(32'h60, 8'd0, 2'b01, 3'd3, -1, 0, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
